dmem_arbiter: RTL and testbench

Two-master arbiter and sequencer for the single-port data memory. Master 0 is the core load/store port; master 1 is a secondary requester such as a DMA or debug unit. The block latches one request at a time, drives the memory command, counts the fixed read latency and returns the read data to the winning master. Arbitration is round-robin, so neither master can starve the other.

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer between two masters and a single-port data memory.
// One command is latched at a time; reads wait a fixed latency and return via a shared register.
module dmem_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [3:0]      m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [3:0]      m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [1:0] LatInit = 2'(RD_LAT - 1);

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            last_q, last_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            win;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    win       = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          // On conflict the master that did not win last time goes first.
          win     = (m0_req && m1_req) ? ~last_q : m1_req;
          sel_d   = win;
          we_d    = win ? m1_we : m0_we;
          be_d    = (win ? m1_we : m0_we) ? (win ? m1_be : m0_be) : 4'hF;
          addr_d  = win ? {m1_addr[AW-1:2], 2'b00} : {m0_addr[AW-1:2], 2'b00};
          wdata_d = win ? m1_wdata : m0_wdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = be_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        m0_gnt    = ~sel_q;
        m1_gnt    = sel_q;
        last_d    = sel_q;
        if (we_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = LatInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_rdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        m0_rvalid = ~sel_q;
        m1_rvalid = sel_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: three instances at RD_LAT 1..3 share stimulus,
// one instance is observed per scenario against expected grant/response events.
module tb_dmem_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 32;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_be = '0, m1_be = '0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

  logic [NDUT-1:0] m0_gnt_w, m0_rvalid_w, m1_gnt_w, m1_rvalid_w, mem_en_w, mem_we_w, busy_w;
  logic [3:0]  mem_be_w    [NDUT];
  logic [31:0] m0_rdata_w  [NDUT];
  logic [31:0] m1_rdata_w  [NDUT];
  logic [31:0] mem_addr_w  [NDUT];
  logic [31:0] mem_wdata_w [NDUT];
  logic [31:0] mem_rdata_w [NDUT];

  int cyc = 0;
  int cur = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_arbiter #(.XLEN(XLEN), .AW(AW), .RD_LAT(g + 1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_be     (m0_be),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt_w[g]),
      .m0_rvalid (m0_rvalid_w[g]),
      .m0_rdata  (m0_rdata_w[g]),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_be     (m1_be),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt_w[g]),
      .m1_rvalid (m1_rvalid_w[g]),
      .m1_rdata  (m1_rdata_w[g]),
      .mem_en    (mem_en_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_be    (mem_be_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g]),
      .busy      (busy_w[g])
    );

    // Memory drives valid data only in the single cycle RD_LAT after mem_en, junk otherwise.
    logic        pend = 1'b0;
    int          left = 0;
    logic [31:0] raddr = '0;
    always @(posedge clk) begin
      if (mem_en_w[g] && !mem_we_w[g]) begin
        pend  <= 1'b1;
        left  <= g + 1;
        raddr <= mem_addr_w[g];
      end else if (pend) begin
        left <= left - 1;
        if (left == 1) pend <= 1'b0;
      end
    end
    assign mem_rdata_w[g] = (pend && left == 1) ? mem_data(raddr) : (32'hBAD0_0000 | 32'(cyc));
  end

  logic        c_m0_gnt, c_m1_gnt, c_m0_rvalid, c_m1_rvalid, c_mem_en, c_mem_we, c_busy;
  logic [3:0]  c_mem_be;
  logic [31:0] c_m0_rdata, c_m1_rdata, c_mem_addr, c_mem_wdata;
  logic        any_out;

  always_comb begin
    c_m0_gnt    = m0_gnt_w[cur];
    c_m1_gnt    = m1_gnt_w[cur];
    c_m0_rvalid = m0_rvalid_w[cur];
    c_m1_rvalid = m1_rvalid_w[cur];
    c_mem_en    = mem_en_w[cur];
    c_mem_we    = mem_we_w[cur];
    c_busy      = busy_w[cur];
    c_mem_be    = mem_be_w[cur];
    c_m0_rdata  = m0_rdata_w[cur];
    c_m1_rdata  = m1_rdata_w[cur];
    c_mem_addr  = mem_addr_w[cur];
    c_mem_wdata = mem_wdata_w[cur];
  end

  always_comb begin
    any_out = |{m0_gnt_w, m0_rvalid_w, m1_gnt_w, m1_rvalid_w, mem_en_w, mem_we_w, busy_w};
    for (int i = 0; i < NDUT; i++) begin
      any_out = any_out | (|m0_rdata_w[i]) | (|m1_rdata_w[i]) | (|mem_be_w[i])
              | (|mem_addr_w[i]) | (|mem_wdata_w[i]);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, dut %0d)", tag, obs, exp, cyc, cur);
    end
  endtask

  typedef struct {
    int          start;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // code: 0 = m0_gnt, 1 = m1_gnt, 2 = m0_rvalid, 3 = m1_rvalid
  typedef struct {
    int          cyc;
    int          code;
    logic [31:0] data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  cmd_t cmd0_q[$];
  cmd_t cmd1_q[$];
  exp_t sb_q[$];

  function automatic void push_cmd(input int m, input int start, input logic we,
                                   input logic [3:0] be, input logic [31:0] addr,
                                   input logic [31:0] wd);
    cmd_t c;
    c.start = start; c.we = we; c.be = be; c.addr = addr; c.wdata = wd;
    if (m == 0) cmd0_q.push_back(c);
    else        cmd1_q.push_back(c);
  endfunction

  function automatic void push_exp(input int cy, input int code, input logic [31:0] data,
                                   input logic we, input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    e.cyc = cy; e.code = code; e.data = data; e.we = we; e.be = be; e.wdata = wd;
    sb_q.push_back(e);
  endfunction

  // Monitor, then master drivers; outputs depend only on DUT state so ordering is safe.
  always @(negedge clk) begin
    logic [3:0] strobes;
    exp_t       e;
    int         code;
    strobes = {c_m1_rvalid, c_m0_rvalid, c_m1_gnt, c_m0_gnt};
    if (strobes != 4'h0) begin
      check_val("strobe_excl", $countones(strobes), 1);
      check_val("busy_on_strobe", c_busy, 1);
      code = strobes[0] ? 0 : strobes[1] ? 1 : strobes[2] ? 2 : 3;
      if (sb_q.size() == 0) begin
        check_val("sb_extra_event", code + 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_val("ev_code", code, e.code);
        check_val("ev_cycle", cyc, e.cyc);
        if (code < 2) begin
          check_val("mem_addr", c_mem_addr, e.data);
          check_val("mem_we", c_mem_we, e.we);
          check_val("mem_be", c_mem_be, e.be);
          if (e.we) check_val("mem_wdata", c_mem_wdata, e.wdata);
        end else begin
          check_val("rdata", (code == 2) ? c_m0_rdata : c_m1_rdata, e.data);
        end
      end
    end
    if (c_mem_en || c_m0_gnt || c_m1_gnt) check_val("en_with_gnt", c_mem_en, c_m0_gnt | c_m1_gnt);
    if (!c_mem_en) check_val("mem_idle_zero", |{c_mem_we, c_mem_be, c_mem_addr, c_mem_wdata}, 0);

    if (c_m0_gnt && cmd0_q.size() > 0) void'(cmd0_q.pop_front());
    if (c_m1_gnt && cmd1_q.size() > 0) void'(cmd1_q.pop_front());
    if (cmd0_q.size() > 0 && cyc >= cmd0_q[0].start) begin
      m0_req = 1'b1; m0_we = cmd0_q[0].we; m0_be = cmd0_q[0].be;
      m0_addr = cmd0_q[0].addr; m0_wdata = cmd0_q[0].wdata;
    end else begin
      m0_req = 1'b0; m0_we = 1'b1; m0_be = 4'hF; m0_addr = '1; m0_wdata = '1;
    end
    if (cmd1_q.size() > 0 && cyc >= cmd1_q[0].start) begin
      m1_req = 1'b1; m1_we = cmd1_q[0].we; m1_be = cmd1_q[0].be;
      m1_addr = cmd1_q[0].addr; m1_wdata = cmd1_q[0].wdata;
    end else begin
      m1_req = 1'b0; m1_we = 1'b1; m1_be = 4'hF; m1_addr = '1; m1_wdata = '1;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    sb_q.delete();
    cmd0_q.delete();
    cmd1_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_val("sb_drain", sb_q.size(), 0);
    sb_q.delete();
    repeat (4) @(posedge clk);
    check_val("cmd_drain", cmd0_q.size() + cmd1_q.size(), 0);
    cmd0_q.delete();
    cmd1_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_outs_held", any_out, 0);
    reset = 1'b0;
    #1;
    check_val("rst_busy", busy_w, 0);
    check_val("rst_outs_release", any_out, 0);

    // m0 read, RD_LAT=2, misaligned address and partial be on a read
    cur = 1;
    @(posedge clk); #1;
    c = cyc;
    push_cmd(0, c, 1'b0, 4'h3, 32'h0000_1007, 32'h1234_5678);
    push_exp(c + 1, 0, 32'h0000_1004, 1'b0, 4'hF, 32'h0);
    push_exp(c + 4, 2, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0);
    wait_drain(20);
    check_val("idle_after_read", c_busy, 0);

    // Reset during WAIT of an m0 read; then first conflict must go to m0
    @(posedge clk); #1;
    c = cyc;
    push_cmd(0, c, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
    push_exp(c + 1, 0, 32'h0000_2000, 1'b0, 4'hF, 32'h0);
    while (cyc < c + 2) @(posedge clk);
    #3;
    check_val("rdata_before_rst", c_m0_rdata, 32'hDEAD_BEEF);
    check_val("busy_in_wait", c_busy, 1);
    reset = 1'b1;
    #1;
    check_val("rst_async_outs", any_out, 0);
    check_val("rst_async_rdata", c_m0_rdata, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    sb_q.delete();
    repeat (6) @(posedge clk);
    #1;
    check_val("rst_rdata_after", c_m0_rdata, 0);
    check_val("rst_busy_after", busy_w, 0);
    c = cyc;
    push_cmd(0, c, 1'b1, 4'h5, 32'h0000_0300, 32'h5555_0000);
    push_cmd(1, c, 1'b1, 4'hA, 32'h0000_0400, 32'h6666_0000);
    push_exp(c + 1, 0, 32'h0000_0300, 1'b1, 4'h5, 32'h5555_0000);
    push_exp(c + 3, 1, 32'h0000_0400, 1'b1, 4'hA, 32'h6666_0000);
    wait_drain(20);

    // Continuous conflicting writes alternate m0, m1 two cycles apart
    do_reset();
    cur = 0;
    @(posedge clk); #1;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      push_cmd(0, c, 1'b1, 4'h1 << k, 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k));
      push_cmd(1, c, 1'b1, 4'hF >> k, 32'h203 + 32'(8 * k), 32'hB000_0000 + 32'(k));
    end
    for (int k = 0; k < 3; k++) begin
      push_exp(c + 1 + 4 * k, 0, 32'h100 + 32'(4 * k), 1'b1, 4'h1 << k,
               32'hA000_0000 + 32'(k));
      push_exp(c + 3 + 4 * k, 1, 32'h200 + 32'(8 * k), 1'b1, 4'hF >> k,
               32'hB000_0000 + 32'(k));
    end
    wait_drain(40);

    // Mixed traffic at RD_LAT=3: m0 raised during m1's read waits for the next IDLE
    do_reset();
    cur = 2;
    @(posedge clk); #1;
    c = cyc;
    push_cmd(1, c, 1'b0, 4'h0, 32'h0000_3008, 32'h0);
    push_cmd(0, c + 2, 1'b1, 4'hC, 32'h0000_0040, 32'hC0FF_EE00);
    push_exp(c + 1, 1, 32'h0000_3008, 1'b0, 4'hF, 32'h0);
    push_exp(c + 5, 3, mem_data(32'h0000_3008), 1'b0, 4'h0, 32'h0);
    push_exp(c + 7, 0, 32'h0000_0040, 1'b1, 4'hC, 32'hC0FF_EE00);
    wait_drain(30);

    // RD_LAT=1 back-to-back m1 reads
    do_reset();
    cur = 0;
    @(posedge clk); #1;
    c = cyc;
    push_cmd(1, c, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    push_cmd(1, c, 1'b0, 4'hF, 32'h0000_0014, 32'h0);
    push_exp(c + 1, 1, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
    push_exp(c + 3, 3, mem_data(32'h0000_0010), 1'b0, 4'h0, 32'h0);
    push_exp(c + 5, 1, 32'h0000_0014, 1'b0, 4'hF, 32'h0);
    push_exp(c + 7, 3, mem_data(32'h0000_0014), 1'b0, 4'h0, 32'h0);
    wait_drain(30);
    #1;
    check_val("rdata_hold_m1", c_m1_rdata, mem_data(32'h0000_0014));
    check_val("rdata_hold_m0", c_m0_rdata, mem_data(32'h0000_0014));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
